// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   Mode-0 (CPOL=0, CPHA=0) SPI master with a one-hot slave-select vector.
//   A single valid/ready request carries up to 32 transmit bits. The reply comes
//   back as a single held valid/ready response containing the bits captured
//   from miso.
//
//   Frame shape, counted in system clocks after the accept edge:
//     ss_n low ....... DIV (setup) + 2*N*DIV (N sck periods) + DIV (hold)
//     rsp_valid ...... rises one cycle after ss_n returns high
//
// Parameters
//   DIV   system clocks per sck half-period (>= 1)
//   SS_W  number of slave-select lines
//
// Ports
//   clock, rst_n            system clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_data[31:0]          transmit bits, right-aligned
//   req_len[4:0]            bit count minus one
//   req_ss[SS_W-1:0]        one-hot select, 1 = select (0 = dummy clocks)
//   rsp_valid/rsp_ready     response handshake; rsp_valid held until consumed
//   rsp_data[31:0]          received bits, right-aligned, upper bits zero
//   sck, ss_n, mosi, miso   SPI bus
//
// Build option
//   SPI_MASTER_LSB_FIRST_EN  when defined, bit 0 is shifted first in both
//                            directions. Otherwise the word is sent MSB-first.
// -----------------------------------------------------------------------------
module spi_master #(
    parameter int DIV  = 2,
    parameter int SS_W = 8
) (
    input  logic            clock,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_data,
    input  logic [4:0]      req_len,
    input  logic [SS_W-1:0] req_ss,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_data,
    output logic            sck,
    output logic [SS_W-1:0] ss_n,
    output logic            mosi,
    input  logic            miso
);

    localparam int            DW       = $clog2(DIV) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0] div_cnt;     // position inside the current half-period
    logic [5:0]    bit_cnt;     // completed bits (falling edges), stops at N
    logic [31:0]   data_q;
    logic [4:0]    len_q;
    logic [31:0]   rx_q;

    logic          tick;        // last cycle of a half-period
    logic          accept;
    logic [5:0]    n_bits;
    logic [5:0]    bit_nxt;
    logic [4:0]    pos_first;   // word index of the first bit on the wire
    logic [4:0]    pos_cur;     // word index of the bit now on the wire
    logic [4:0]    pos_nxt;     // word index of the bit after it

    assign req_ready = (state_q == IDLE) && !rsp_valid;
    assign accept    = req_valid && req_ready;
    assign tick      = (div_cnt == DIV_LAST);
    assign n_bits    = {1'b0, len_q} + 6'd1;
    assign bit_nxt   = bit_cnt + 6'd1;
    assign rsp_data  = rx_q;

    // The transmit and receive positions come from the same mapping, so a
    // loopback always returns the request word unchanged in either bit order.
`ifdef SPI_MASTER_LSB_FIRST_EN
    assign pos_first = 5'd0;
    assign pos_cur   = bit_cnt[4:0];
    assign pos_nxt   = bit_nxt[4:0];
`else
    assign pos_first = req_len;
    assign pos_cur   = len_q - bit_cnt[4:0];
    assign pos_nxt   = len_q - bit_nxt[4:0];
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = SETUP;
            SETUP: if (tick) state_d = XFER;
            // XFER also covers the low half-period that follows the last
            // falling edge. HOLD then adds its own DIV cycles.
            XFER:  if (tick && !sck && (bit_cnt == n_bits)) state_d = HOLD;
            HOLD:  if (tick) state_d = DONE;
            DONE:  if (rsp_valid && rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            data_q    <= '0;
            len_q     <= '0;
            rx_q      <= '0;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            ss_n      <= '1;
            rsp_valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_q  <= req_data;
                        len_q   <= req_len;
                        rx_q    <= '0;
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        ss_n    <= ~req_ss;
                        mosi    <= req_data[pos_first];
                    end
                end

                SETUP: begin
                    div_cnt <= tick ? '0 : div_cnt + DW'(1);
                    if (tick) begin
                        // First rising edge: sample miso as it is before the
                        // slave reacts to this edge.
                        sck           <= 1'b1;
                        rx_q[pos_cur] <= miso;
                    end
                end

                XFER: begin
                    div_cnt <= tick ? '0 : div_cnt + DW'(1);
                    if (tick) begin
                        if (sck) begin
                            sck     <= 1'b0;
                            bit_cnt <= bit_nxt;
                            // After the last bit, mosi keeps its value.
                            if (bit_nxt < n_bits) mosi <= data_q[pos_nxt];
                        end else if (bit_cnt < n_bits) begin
                            sck           <= 1'b1;
                            rx_q[pos_cur] <= miso;
                        end
                    end
                end

                HOLD: begin
                    div_cnt <= tick ? '0 : div_cnt + DW'(1);
                    if (tick) ss_n <= '1;
                end

                DONE: begin
                    // Rises on the first DONE cycle and falls right after the
                    // consume, when the FSM is back in IDLE.
                    rsp_valid <= !(rsp_valid && rsp_ready);
                end

                default: ;
            endcase
        end
    end

endmodule
